// File: rtl/vga_pkg.sv
// Shared VGA constants and the rectangle controller state encoding.
package vga_pkg;

  localparam int VGA_HOR_PIX = 800;
  localparam int VGA_VER_PIX = 600;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FALL   = 2'd1,
    ST_LANDED = 2'd2
  } rect_state_t;

  // Saturate a 12-bit coordinate at an upper limit.
  function automatic logic [11:0] clamp12(input logic [11:0] value, input logic [11:0] limit);
    logic [11:0] result;
    if (value > limit) result = limit;
    else               result = value;
    return result;
  endfunction

endpackage

// File: rtl/rect_ctl_edge_det.sv
// Registered rising-edge detector. The first sample after reset only primes
// the history, so a level already high at reset release never fires.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic armed_r;
  logic level_r;
  logic rise_r;

  // Level history and one-cycle rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      armed_r <= 1'b1;
      level_r <= level;
      rise_r  <= armed_r & level & ~level_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/rect_ctl.sv
// Rectangle controller: follows the pointer, drops under gravity on a click,
// lands on the floor, and returns to pointer-follow on the next click.
module rect_ctl
  import vga_pkg::*;
#(
  parameter int RECT_WIDTH  = 48,
  parameter int RECT_LENGTH = 64,
  parameter int HOR_PIX     = VGA_HOR_PIX,
  parameter int VER_PIX     = VGA_VER_PIX,
  parameter int ACCEL       = 1,
  parameter int V_MAX       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  state_o
);

  localparam logic [11:0] X_MAX   = 12'(HOR_PIX - RECT_LENGTH - 1);
  localparam logic [11:0] FLOOR   = 12'(VER_PIX - RECT_WIDTH - 1);
  localparam logic [8:0]  ACCEL_W = 9'(ACCEL);
  localparam logic [8:0]  V_MAX_W = 9'(V_MAX);

  rect_state_t state_r, state_nxt_s;
  logic [11:0] xpos_r, xpos_nxt_s;
  logic [11:0] ypos_r, ypos_nxt_s;
  logic [7:0]  vel_r, vel_nxt_s;
  logic        frame_tick_s;
  logic        click_s;
  logic [8:0]  vel_inc_s;
  logic [7:0]  vel_new_s;
  logic [12:0] ysum_s;

  edge_det u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (vsync_in),
    .rise  (frame_tick_s)
  );

  edge_det u_click_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (mouse_left),
    .rise  (click_s)
  );

  // Candidate velocity and landing sum; the 13-bit sum cannot wrap
  always_comb begin
    vel_inc_s = {1'b0, vel_r} + ACCEL_W;
    if (vel_inc_s > V_MAX_W) vel_new_s = V_MAX_W[7:0];
    else                     vel_new_s = vel_inc_s[7:0];
    ysum_s = {1'b0, ypos_r} + {5'd0, vel_new_s};
  end

  // Next-state and next-position logic
  always_comb begin
    state_nxt_s = state_r;
    xpos_nxt_s  = xpos_r;
    ypos_nxt_s  = ypos_r;
    vel_nxt_s   = vel_r;
    case (state_r)
      ST_IDLE: begin
        xpos_nxt_s = clamp12(mouse_xpos, X_MAX);
        ypos_nxt_s = clamp12(mouse_ypos, FLOOR);
        if (click_s) begin
          state_nxt_s = ST_FALL;
          vel_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FALL: begin
        if (frame_tick_s) begin
          if (ysum_s >= {1'b0, FLOOR}) begin
            ypos_nxt_s  = FLOOR;
            vel_nxt_s   = 8'd0;
            state_nxt_s = ST_LANDED;
          end else begin
            ypos_nxt_s = ysum_s[11:0];
            vel_nxt_s  = vel_new_s;
          end
        end else begin
          state_nxt_s = ST_FALL;
        end
      end
      ST_LANDED: begin
        if (click_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_LANDED;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        vel_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, position and velocity registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      xpos_r  <= 12'd0;
      ypos_r  <= 12'd0;
      vel_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      xpos_r  <= xpos_nxt_s;
      ypos_r  <= ypos_nxt_s;
      vel_r   <= vel_nxt_s;
    end
  end

  assign xpos    = xpos_r;
  assign ypos    = ypos_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_rect_ctl.sv
// Self-checking bench for rect_ctl: follow table, hand-written fall/landing/
// reset sequences, and a randomized run against a behavioural model.
module tb_rect_ctl;

  localparam int X_MAX = 735;
  localparam int FLOOR = 551;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_in = 1'b0;
  logic [11:0] mouse_xpos = 12'd0;
  logic [11:0] mouse_ypos = 12'd0;
  logic        mouse_left = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  rect_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync_in   (vsync_in),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos       (xpos),
    .ypos       (ypos),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 follow, 1 falling, 2 landed
  int m_mode, m_x, m_y, m_v;
  bit vs_prev, ml_prev, armed, tick_pend, click_pend;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_v = 0;
    vs_prev = 1'b0; ml_prev = 1'b0; armed = 1'b0;
    tick_pend = 1'b0; click_pend = 1'b0;
  endtask

  task automatic model_edge();
    bit t, c;
    if (!rst_n) begin
      model_reset();
    end else begin
      t = tick_pend;
      c = click_pend;
      if (m_mode == 0) begin
        m_x = imin(int'(mouse_xpos), X_MAX);
        m_y = imin(int'(mouse_ypos), FLOOR);
        if (c) begin m_mode = 1; m_v = 0; end
      end else if (m_mode == 1) begin
        if (t) begin
          m_v = imin(m_v + 1, 16);
          if (m_y + m_v >= FLOOR) begin
            m_y = FLOOR; m_v = 0; m_mode = 2;
          end else begin
            m_y = m_y + m_v;
          end
        end
      end else begin
        if (c) m_mode = 0;
      end
      tick_pend  = armed && vsync_in && !vs_prev;
      click_pend = armed && mouse_left && !ml_prev;
      vs_prev = vsync_in;
      ml_prev = mouse_left;
      armed   = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [12:0] act, input int exp);
    checks++;
    if (act !== 13'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_state", {11'd0, state_o}, m_mode);
    chk("model_xpos", {1'b0, xpos}, m_x);
    chk("model_ypos", {1'b0, ypos}, m_y);
  endtask

  task automatic do_tick();
    vsync_in = 1'b1;
    cycle();
    cycle();
    vsync_in = 1'b0;
    cycle();
  endtask

  task automatic do_click();
    mouse_left = 1'b1;
    cycle();
    mouse_left = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
  endtask

  typedef struct {
    logic [11:0] mx, my;
    int          ex, ey;
  } vec_t;

  vec_t vecs[6];
  int   prof_fall[5] = '{101, 103, 106, 110, 115};
  int   prof_land[5] = '{541, 543, 546, 550, 551};

  initial begin
    int prev_y, step, vs_cnt;

    vecs[0] = '{12'd900,  12'd700,  735, 551};
    vecs[1] = '{12'd10,   12'd20,   10,  20};
    vecs[2] = '{12'd735,  12'd551,  735, 551};
    vecs[3] = '{12'd736,  12'd552,  735, 551};
    vecs[4] = '{12'd0,    12'd0,    0,   0};
    vecs[5] = '{12'd4095, 12'd4095, 735, 551};

    // Reset state
    model_reset();
    #1;
    chk("reset_x", {1'b0, xpos}, 0);
    chk("reset_y", {1'b0, ypos}, 0);
    chk("reset_state", {11'd0, state_o}, 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();

    // IDLE follow table
    for (int i = 0; i < 6; i++) begin
      mouse_xpos = vecs[i].mx;
      mouse_ypos = vecs[i].my;
      cycle();
      chk("follow_x", {1'b0, xpos}, vecs[i].ex);
      chk("follow_y", {1'b0, ypos}, vecs[i].ey);
    end

    // Fall profile, pointer moves and a stray click are ignored while falling
    mouse_xpos = 12'd200; mouse_ypos = 12'd100;
    cycle();
    do_click();
    chk("fall_entry_state", {11'd0, state_o}, 1);
    chk("fall_entry_y", {1'b0, ypos}, 100);
    mouse_xpos = 12'd400; mouse_ypos = 12'd400;
    for (int k = 0; k < 5; k++) begin
      do_tick();
      chk("fall_y", {1'b0, ypos}, prof_fall[k]);
      chk("fall_x", {1'b0, xpos}, 200);
      if (k == 2) begin
        do_click();
        chk("fall_click_ignored", {11'd0, state_o}, 1);
      end
    end

    // Landing exactly on the floor, then click back to follow
    do_reset();
    mouse_xpos = 12'd300; mouse_ypos = 12'd540;
    cycle();
    do_click();
    for (int k = 0; k < 5; k++) begin
      do_tick();
      chk("land_y", {1'b0, ypos}, prof_land[k]);
    end
    chk("land_state", {11'd0, state_o}, 2);
    do_tick();
    chk("landed_hold_y", {1'b0, ypos}, FLOOR);
    chk("landed_hold_x", {1'b0, xpos}, 300);
    mouse_xpos = 12'd20; mouse_ypos = 12'd30;
    do_click();
    chk("unland_state", {11'd0, state_o}, 0);
    cycle();
    chk("resume_x", {1'b0, xpos}, 20);
    chk("resume_y", {1'b0, ypos}, 30);

    // Coincident click and vsync edge
    mouse_xpos = 12'd50; mouse_ypos = 12'd60;
    cycle();
    mouse_left = 1'b1; vsync_in = 1'b1;
    cycle();
    mouse_left = 1'b0; vsync_in = 1'b0;
    cycle();
    chk("coinc_state", {11'd0, state_o}, 1);
    chk("coinc_y", {1'b0, ypos}, 60);
    cycle();
    cycle();
    chk("coinc_y_hold", {1'b0, ypos}, 60);
    do_tick();
    chk("coinc_first_tick", {1'b0, ypos}, 61);

    // Velocity cap
    do_reset();
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    cycle();
    do_click();
    prev_y = 0;
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      step = int'(ypos) - prev_y;
      chk("vel_step", 13'(step), imin(k, 16));
      prev_y = int'(ypos);
    end
    chk("vel_cap_y", {1'b0, ypos}, 200);

    // Reset mid-fall with the button held through release
    do_reset();
    mouse_xpos = 12'd200; mouse_ypos = 12'd100;
    cycle();
    do_click();
    for (int k = 0; k < 3; k++) do_tick();
    chk("pre_reset_y", {1'b0, ypos}, 106);
    mouse_left = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midfall_reset_x", {1'b0, xpos}, 0);
    chk("midfall_reset_y", {1'b0, ypos}, 0);
    chk("midfall_reset_state", {11'd0, state_o}, 0);
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("held_button_state", {11'd0, state_o}, 0);
    chk("held_button_x", {1'b0, xpos}, 200);
    chk("held_button_y", {1'b0, ypos}, 100);
    mouse_left = 1'b0;
    cycle();

    // Randomized run against the model
    vs_cnt = 0;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        mouse_xpos = 12'($urandom_range(0, 4095));
        mouse_ypos = 12'($urandom_range(0, 4095));
      end else begin
        mouse_xpos = 12'($urandom_range(0, 900));
        mouse_ypos = 12'($urandom_range(0, 700));
      end
      if (vs_cnt == 0) begin
        vsync_in = ~vsync_in;
        vs_cnt = $urandom_range(1, 8);
      end else begin
        vs_cnt--;
      end
      if ($urandom_range(0, 40) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
